// File: rtl/led_activity_ctrl.sv
// RX/TX LED pattern generator: link/error status on LED[0],
// stretched activity flashes with an enforced dark gap on LED[1].
module led_activity_chan #(
    parameter int unsigned P_ON_CYC     = 2000000,
    parameter int unsigned P_OFF_CYC    = 2000000,
    parameter int unsigned P_BLINK_HALF = 8000000,
    parameter int unsigned P_ERR_HOLD   = 40000000
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_boot_done,
    input  logic       i_link,
    input  logic       i_act,
    input  logic       i_err,
    output logic [1:0] o_led
);

    localparam int CW = 26;
    localparam logic [CW-1:0] ON_LAST  = CW'(P_ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(P_OFF_CYC - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'(P_BLINK_HALF - 1);
    localparam logic [CW-1:0] HOLD     = CW'(P_ERR_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF
    } act_st_t;

    act_st_t       state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pend, pend_n;
    logic [CW-1:0] tmr, tmr_n;
    logic [CW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n;
    logic [1:0]    led_n;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            tmr   <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
            o_led <= 2'b00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            tmr   <= tmr_n;
            bcnt  <= bcnt_n;
            phase <= phase_n;
            o_led <= led_n;
        end
    end

    // Activity stretcher; strobes arriving mid-flash or mid-gap collapse into pend
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        if (!i_boot_done) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            pend_n  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_act) begin
                        state_n = ST_ON;
                        cnt_n   = '0;
                    end
                end
                ST_ON: begin
                    if (i_act) pend_n = 1'b1;
                    if (cnt == ON_LAST) begin
                        state_n = ST_OFF;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_OFF: begin
                    if (cnt == OFF_LAST) begin
                        state_n = (pend || i_act) ? ST_ON : ST_IDLE;
                        cnt_n   = '0;
                        pend_n  = 1'b0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                        if (i_act) pend_n = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                end
            endcase
        end
    end

    // Error hold timer with blink phase; keeps running while link is down
    always_comb begin
        tmr_n   = tmr;
        bcnt_n  = bcnt;
        phase_n = phase;
        if (!i_boot_done) begin
            tmr_n   = '0;
            bcnt_n  = '0;
            phase_n = 1'b0;
        end else if (i_err) begin
            tmr_n   = HOLD;
            bcnt_n  = '0;
            phase_n = 1'b1;
        end else if (tmr != '0) begin
            tmr_n = tmr - CW'(1);
            if (bcnt == BL_LAST) begin
                bcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                bcnt_n = bcnt + CW'(1);
            end
        end
    end

    always_comb begin
        led_n    = 2'b00;
        led_n[1] = (state_n == ST_ON);
        if (i_link) begin
            led_n[0] = (tmr_n != '0) ? phase_n : 1'b1;
        end
    end

endmodule

module led_activity_ctrl #(
    parameter int unsigned P_ON_CYC     = 2000000,
    parameter int unsigned P_OFF_CYC    = 2000000,
    parameter int unsigned P_BLINK_HALF = 8000000,
    parameter int unsigned P_ERR_HOLD   = 40000000
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_boot_done,
    input  logic       i_rx_link,
    input  logic       i_rx_act,
    input  logic       i_rx_err,
    input  logic       i_tx_link,
    input  logic       i_tx_act,
    input  logic       i_tx_err,
    output logic [1:0] o_rx_led,
    output logic [1:0] o_tx_led
);

    led_activity_chan #(
        .P_ON_CYC    (P_ON_CYC),
        .P_OFF_CYC   (P_OFF_CYC),
        .P_BLINK_HALF(P_BLINK_HALF),
        .P_ERR_HOLD  (P_ERR_HOLD)
    ) u_rx (
        .i_clk      (i_clk),
        .i_res_n    (i_res_n),
        .i_boot_done(i_boot_done),
        .i_link     (i_rx_link),
        .i_act      (i_rx_act),
        .i_err      (i_rx_err),
        .o_led      (o_rx_led)
    );

    led_activity_chan #(
        .P_ON_CYC    (P_ON_CYC),
        .P_OFF_CYC   (P_OFF_CYC),
        .P_BLINK_HALF(P_BLINK_HALF),
        .P_ERR_HOLD  (P_ERR_HOLD)
    ) u_tx (
        .i_clk      (i_clk),
        .i_res_n    (i_res_n),
        .i_boot_done(i_boot_done),
        .i_link     (i_tx_link),
        .i_act      (i_tx_act),
        .i_err      (i_tx_err),
        .o_led      (o_tx_led)
    );

endmodule

// File: tb/tb_led_activity_ctrl.sv
// Directed bench for led_activity_ctrl with a queue of expected
// {rx_led, tx_led} values checked one cycle after each stimulus step.
module tb_led_activity_ctrl;

    logic       clk = 1'b0;
    logic       res_n;
    logic       boot;
    logic       rx_link, rx_act, rx_err;
    logic       tx_link, tx_act, tx_err;
    logic [1:0] rx_led, tx_led;

    int tests = 0;
    int fails = 0;
    logic [3:0] sb [$];
    bit p [0:9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

    always #5 clk = ~clk;

    led_activity_ctrl #(
        .P_ON_CYC    (4),
        .P_OFF_CYC   (3),
        .P_BLINK_HALF(2),
        .P_ERR_HOLD  (10)
    ) dut (
        .i_clk      (clk),
        .i_res_n    (res_n),
        .i_boot_done(boot),
        .i_rx_link  (rx_link),
        .i_rx_act   (rx_act),
        .i_rx_err   (rx_err),
        .i_tx_link  (tx_link),
        .i_tx_act   (tx_act),
        .i_tx_err   (tx_err),
        .o_rx_led   (rx_led),
        .o_tx_led   (tx_led)
    );

    task automatic tick(input string tag, input logic [1:0] erx, input logic [1:0] etx);
        logic [3:0] e;
        sb.push_back({erx, etx});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests++;
        assert ({rx_led, tx_led} === e) else begin
            fails++;
            $error("FAIL %s: rx/tx got %b/%b exp %b/%b", tag, rx_led, tx_led, e[3:2], e[1:0]);
        end
    endtask

    initial begin
        logic [1:0] erx, etx;
        logic [5:0] r;
        res_n = 1'b0;
        boot = 1'b1;
        {rx_link, rx_act, rx_err, tx_link, tx_act, tx_err} = '0;

        // 1: reset hold with toggling inputs, then release with link down
        for (int i = 0; i < 4; i++) begin
            r = 6'($urandom);
            {rx_link, rx_act, rx_err, tx_link, tx_act, tx_err} = r;
            tick("reset_hold", 2'b00, 2'b00);
        end
        {rx_link, rx_act, rx_err, tx_link, tx_act, tx_err} = '0;
        res_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("reset_rel", 2'b00, 2'b00);

        // 2: single act pulse, then a new pulse once idle
        for (int rep = 0; rep < 2; rep++) begin
            rx_act = 1'b1;
            tick("single_on", 2'b10, 2'b00);
            rx_act = 1'b0;
            for (int k = 2; k <= 4; k++) tick("single_on", 2'b10, 2'b00);
            for (int k = 5; k <= 7; k++) tick("single_off", 2'b00, 2'b00);
            tick("single_idle", 2'b00, 2'b00);
        end

        // 3: act held 20 cycles on TX -> 4 on / 3 off repeating
        for (int k = 1; k <= 28; k++) begin
            tx_act = (k <= 20);
            etx = {(((k - 1) % 7) < 4) ? 1'b1 : 1'b0, 1'b0};
            tick("held_act", 2'b00, etx);
        end
        tx_act = 1'b0;
        tick("held_idle", 2'b00, 2'b00);
        tick("held_idle", 2'b00, 2'b00);

        // 3b: act on the last dark cycle starts a new flash immediately
        rx_act = 1'b1;
        tick("lastoff", 2'b10, 2'b00);
        rx_act = 1'b0;
        for (int k = 2; k <= 7; k++) tick("lastoff", (k <= 4) ? 2'b10 : 2'b00, 2'b00);
        rx_act = 1'b1;
        tick("lastoff_new", 2'b10, 2'b00);
        rx_act = 1'b0;
        for (int k = 9; k <= 14; k++) tick("lastoff_new", (k <= 11) ? 2'b10 : 2'b00, 2'b00);
        tick("lastoff_idle", 2'b00, 2'b00);

        // 4: error blink pattern, then a retrigger at N+6
        rx_link = 1'b1;
        tick("link_up", 2'b01, 2'b00);
        rx_err = 1'b1;
        tick("err_blink", {1'b0, p[0]}, 2'b00);
        rx_err = 1'b0;
        for (int k = 2; k <= 10; k++) tick("err_blink", {1'b0, p[k-1]}, 2'b00);
        tick("err_solid", 2'b01, 2'b00);
        tick("err_solid", 2'b01, 2'b00);
        rx_err = 1'b1;
        tick("err_re", {1'b0, p[0]}, 2'b00);
        rx_err = 1'b0;
        for (int k = 2; k <= 6; k++) tick("err_re", {1'b0, p[k-1]}, 2'b00);
        rx_err = 1'b1;
        tick("err_restart", {1'b0, p[0]}, 2'b00);
        rx_err = 1'b0;
        for (int k = 2; k <= 10; k++) tick("err_restart", {1'b0, p[k-1]}, 2'b00);
        tick("err_solid2", 2'b01, 2'b00);

        // 5: boot falling mid-flash aborts, pending discarded
        rx_act = 1'b1;
        tick("boot_abort", 2'b11, 2'b00);
        rx_act = 1'b0;
        tick("boot_abort", 2'b11, 2'b00);
        rx_act = 1'b1;
        tick("boot_abort", 2'b11, 2'b00);
        rx_act = 1'b0;
        boot = 1'b0;
        tick("boot_abort", 2'b01, 2'b00);
        {rx_act, rx_err, tx_act, tx_err} = 4'b1111;
        tick("boot_gate", 2'b01, 2'b00);
        {rx_act, rx_err, tx_act, tx_err} = 4'b0000;
        tx_link = 1'b1;
        tick("boot_gate_link", 2'b01, 2'b01);
        {rx_act, rx_err, tx_act, tx_err} = 4'b1111;
        tick("boot_gate", 2'b01, 2'b01);
        {rx_act, rx_err, tx_act, tx_err} = 4'b0000;
        boot = 1'b1;
        for (int k = 0; k < 6; k++) tick("boot_nostale", 2'b01, 2'b01);
        rx_err = 1'b1;
        tick("boot_errclr", 2'b01, 2'b01);
        rx_err = 1'b0;
        tick("boot_errclr", 2'b01, 2'b01);
        tick("boot_errclr", 2'b00, 2'b01);
        boot = 1'b0;
        tick("boot_errclr", 2'b01, 2'b01);
        boot = 1'b1;
        tick("boot_errclr", 2'b01, 2'b01);
        tick("boot_errclr", 2'b01, 2'b01);

        // 6: RX act + TX err together, RX link drop during the flash
        for (int k = 1; k <= 12; k++) begin
            rx_act = (k == 1);
            tx_err = (k == 1);
            if (k == 3) rx_link = 1'b0;
            erx = {(k <= 4) ? 1'b1 : 1'b0, (k <= 2) ? 1'b1 : 1'b0};
            etx = {1'b0, (k <= 10) ? p[k-1] : 1'b1};
            tick("indep", erx, etx);
        end
        rx_act = 1'b0;
        tx_err = 1'b0;
        // simultaneous act+err on one channel
        for (int k = 1; k <= 12; k++) begin
            tx_act = (k == 1);
            tx_err = (k == 1);
            etx = {(k <= 4) ? 1'b1 : 1'b0, (k <= 10) ? p[k-1] : 1'b1};
            tick("act_err", 2'b00, etx);
        end
        tx_act = 1'b0;
        tx_err = 1'b0;

        // asynchronous reset mid-flash
        rx_link = 1'b1;
        rx_act = 1'b1;
        tick("pre_rst", 2'b11, 2'b01);
        rx_act = 1'b0;
        tick("pre_rst", 2'b11, 2'b01);
        #1;
        res_n = 1'b0;
        #1;
        tests++;
        assert ({rx_led, tx_led} === 4'b0000) else begin
            fails++;
            $error("FAIL async_rst: rx/tx got %b/%b exp 00/00", rx_led, tx_led);
        end
        tick("rst_hold", 2'b00, 2'b00);
        res_n = 1'b1;
        tick("rst_rel", 2'b01, 2'b01);
        tick("rst_rel", 2'b01, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
